// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_pkg: shared definitions for the bit-serial adder controller.
//   state_t       - controller FSM states (IDLE, RUN, DONE)
//   DEFAULT_WIDTH - default operand width in bits
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_add_ctrl_hw_sum.sv
// hw_sum: single-bit combinational full adder, the only arithmetic in the
// serial adder datapath.
// Ports:
//   A, B : input  operand bits
//   C    : input  carry-in
//   S    : output sum bit
//   Co   : output carry-out
module hw_sum (
    input  logic A,
    input  logic B,
    input  logic C,
    output logic S,
    output logic Co
);

    assign S  = A ^ B ^ C;
    assign Co = (A & B) | (A & C) | (B & C);

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: computes {cout,sum} = a + b + cin one bit per clock,
// LSB first, using a single full adder (hw_sum).
// Build option: define SERIAL_ADD_SUB_EN to add the 'sub' input; when sub=1
// at acceptance the block computes a - b as a + ~b + 1 (cin ignored,
// cout=1 means no borrow).
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (ready only in IDLE)
//   a, b, cin           : unsigned operands and carry-in
//   sub                 : subtract select (SERIAL_ADD_SUB_EN only)
//   out_valid/out_ready : result handshake
//   sum, cout           : result, held while out_valid is high
//   busy                : high while bits are being processed (RUN)
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;
    logic             cout_r;
    logic             out_valid_r;

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic             fa_s;
    logic             fa_co;
    logic             last;

    // Subtraction is folded into the operands at acceptance so the RUN
    // datapath is identical for both operations.
    always_comb begin
        b_eff   = b;
        cin_eff = cin;
`ifdef SERIAL_ADD_SUB_EN
        if (sub) begin
            b_eff   = ~b;
            cin_eff = 1'b1;
        end
`endif
    end

    hw_sum u_hw_sum (
        .A  (a_sh[0]),
        .B  (b_sh[0]),
        .C  (carry_r),
        .S  (fa_s),
        .Co (fa_co)
    );

    assign last = (cnt == LAST_BIT);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    if (out_valid_r && out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            a_sh        <= '0;
            b_sh        <= '0;
            sum_r       <= '0;
            carry_r     <= 1'b0;
            cout_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh    <= a;
                        b_sh    <= b_eff;
                        carry_r <= cin_eff;
                        cnt     <= '0;
                        sum_r   <= '0;
                        cout_r  <= 1'b0;
                    end
                end
                RUN: begin
                    // Sum bits enter at the MSB; after WIDTH shifts bit 0
                    // of the result has reached position 0.
                    sum_r   <= {fa_s, sum_r[WIDTH-1:1]};
                    carry_r <= fa_co;
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    cnt     <= cnt + 1'b1;
                    if (last) cout_r <= fa_co;
                end
                DONE: begin
                    // out_valid rises one cycle after DONE entry and drops
                    // on the handshake edge, together with the return to IDLE.
                    if (!out_valid_r)
                        out_valid_r <= 1'b1;
                    else if (out_ready)
                        out_valid_r <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == RUN);
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;

endmodule
